seven_seg_io: RTL and testbench

//   Memory-mapped display/switch I/O block for the pipelined CPU frame on the DE0-CV board.

---
 rtl/seven_seg_io.sv | 137 +++++++++++++
 tb/tb_seven_seg_io.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_io.sv
// Memory-mapped display and switch I/O for the pipelined CPU on the DE0-CV board.
// Holds the HEX register (six seven-segment digits) and the LEDR register, both
// written by CPU stores, and returns KEY/SW values for CPU loads.

// Nibble to active-low seven-segment pattern (bit0=a .. bit6=g), with blanking input.
module seven_seg_decoder (
    input  logic [3:0] nibble,
    input  logic       off,
    output logic [6:0] seg
);

    // Translate the nibble to its segment pattern, or blank the digit when off is set
    always_comb begin
        seg = 7'h7F;
        if (off) begin
            seg = 7'h7F;
        end else begin
            case (nibble)
                4'h0:    seg = 7'h40;
                4'h1:    seg = 7'h79;
                4'h2:    seg = 7'h24;
                4'h3:    seg = 7'h30;
                4'h4:    seg = 7'h19;
                4'h5:    seg = 7'h12;
                4'h6:    seg = 7'h02;
                4'h7:    seg = 7'h78;
                4'h8:    seg = 7'h00;
                4'h9:    seg = 7'h10;
                4'hA:    seg = 7'h08;
                4'hB:    seg = 7'h03;
                4'hC:    seg = 7'h46;
                4'hD:    seg = 7'h21;
                4'hE:    seg = 7'h06;
                4'hF:    seg = 7'h0E;
                default: seg = 7'h7F;
            endcase
        end
    end

endmodule

module seven_seg_io #(
    parameter int               DBITS    = 32,
    parameter logic [DBITS-1:0] ADDRHEX  = 32'hFFFFF000,
    parameter logic [DBITS-1:0] ADDRLEDR = 32'hFFFFF020,
    parameter logic [DBITS-1:0] ADDRKEY  = 32'hFFFFF080,
    parameter logic [DBITS-1:0] ADDRSW   = 32'hFFFFF090,
    parameter logic [23:0]      HEXRESET = 24'hFEDEAD
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [DBITS-1:0] addr,
    input  logic [DBITS-1:0] wdata,
    output logic [DBITS-1:0] rdata,
    output logic             io_hit,
    input  logic [3:0]       key,
    input  logic [9:0]       sw,
    output logic [6:0]       hex0,
    output logic [6:0]       hex1,
    output logic [6:0]       hex2,
    output logic [6:0]       hex3,
    output logic [6:0]       hex4,
    output logic [6:0]       hex5,
    output logic [9:0]       ledr
);

    logic [23:0] hex_r;
    logic [9:0]  ledr_r;
    logic        wr_hex_s;
    logic        wr_ledr_s;
    logic [6:0]  seg_s [6];
    logic        unused_wdata_s;

    // Only the low 24 data bits reach the HEX register; the upper byte is dropped
    assign unused_wdata_s = ^wdata[DBITS-1:24];

    // Full-width address compare: aliases of the register addresses are not decoded
    assign wr_hex_s  = wr_en && (addr == ADDRHEX);
    assign wr_ledr_s = wr_en && (addr == ADDRLEDR);

    // HEX register: reset to the power-on banner, loaded by stores to ADDRHEX
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hex_r <= HEXRESET;
        end else if (wr_hex_s) begin
            hex_r <= wdata[23:0];
        end else begin
            hex_r <= hex_r;
        end
    end

    // LEDR register: cleared on reset, loaded by stores to ADDRLEDR
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ledr_r <= 10'h000;
        end else if (wr_ledr_s) begin
            ledr_r <= wdata[9:0];
        end else begin
            ledr_r <= ledr_r;
        end
    end

    // One decoder per digit; digit N shows HEX bits [4N+3:4N], never blanked here
    for (genvar gi = 0; gi < 6; gi++) begin : g_digit
        seven_seg_decoder u_dec (
            .nibble (hex_r[4*gi +: 4]),
            .off    (1'b0),
            .seg    (seg_s[gi])
        );
    end

    assign hex0 = seg_s[0];
    assign hex1 = seg_s[1];
    assign hex2 = seg_s[2];
    assign hex3 = seg_s[3];
    assign hex4 = seg_s[4];
    assign hex5 = seg_s[5];
    assign ledr = ledr_r;

    // Load path: keys are inverted so a pressed key reads as 1; io_hit steers the CPU mux
    always_comb begin
        rdata  = {DBITS{1'b0}};
        io_hit = 1'b0;
        if (addr == ADDRKEY) begin
            rdata  = {{(DBITS-4){1'b0}}, ~key};
            io_hit = 1'b1;
        end else if (addr == ADDRSW) begin
            rdata  = {{(DBITS-10){1'b0}}, sw};
            io_hit = 1'b1;
        end else begin
            rdata  = {DBITS{1'b0}};
            io_hit = 1'b0;
        end
    end

endmodule

// File: tb/tb_seven_seg_io.sv
// Self-checking bench for seven_seg_io: directed steps plus randomized stores/loads
// compared against a behavioural model of the register file and digit font.
module tb_seven_seg_io;

    localparam logic [31:0] A_HEX  = 32'hFFFFF000;
    localparam logic [31:0] A_LEDR = 32'hFFFFF020;
    localparam logic [31:0] A_KEY  = 32'hFFFFF080;
    localparam logic [31:0] A_SW   = 32'hFFFFF090;

    logic        clk;
    logic        reset;
    logic        wr_en;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        io_hit;
    logic [3:0]  key;
    logic [9:0]  sw;
    logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;
    logic [9:0]  ledr;

    int n_cmp;
    int n_err;

    // Model state
    logic [23:0] hex_m;
    logic [9:0]  ledr_m;
    logic [6:0]  font [16];

    seven_seg_io dut (
        .clk    (clk),
        .reset  (reset),
        .wr_en  (wr_en),
        .addr   (addr),
        .wdata  (wdata),
        .rdata  (rdata),
        .io_hit (io_hit),
        .key    (key),
        .sw     (sw),
        .hex0   (hex0),
        .hex1   (hex1),
        .hex2   (hex2),
        .hex3   (hex3),
        .hex4   (hex4),
        .hex5   (hex5),
        .ledr   (ledr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compare all digits and LEDs against the model
    task automatic check_display(input string tag);
        logic [6:0] h [6];
        h[0] = hex0; h[1] = hex1; h[2] = hex2;
        h[3] = hex3; h[4] = hex4; h[5] = hex5;
        for (int i = 0; i < 6; i++)
            check($sformatf("%s.hex%0d", tag, i), {57'd0, h[i]}, {57'd0, font[hex_m[4*i +: 4]]});
        check({tag, ".ledr"}, {54'd0, ledr}, {54'd0, ledr_m});
    endtask

    // Compare the load path against the model's view of the current inputs
    task automatic check_read(input string tag);
        logic [31:0] exp_d;
        logic        exp_h;
        exp_h = (addr == A_KEY) || (addr == A_SW);
        if (addr == A_KEY)     exp_d = 32'(4'hF - key);
        else if (addr == A_SW) exp_d = 32'(sw);
        else                   exp_d = 32'd0;
        check({tag, ".rdata"}, {32'd0, rdata}, {32'd0, exp_d});
        check({tag, ".io_hit"}, {63'd0, io_hit}, {63'd0, exp_h});
    endtask

    // One bus cycle; inputs applied now (away from the edge), model updated after the edge
    task automatic bus_cycle(input logic we, input logic [31:0] a, input logic [31:0] d);
        wr_en = we;
        addr  = a;
        wdata = d;
        @(posedge clk);
        #1;
        if (we && a == A_HEX)  hex_m  = d[23:0];
        if (we && a == A_LEDR) ledr_m = d[9:0];
        wr_en = 1'b0;
    endtask

    initial begin
        logic [31:0] addr_pool [7];
        n_cmp = 0;
        n_err = 0;
        font = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        hex_m  = 24'hFEDEAD;
        ledr_m = 10'h000;
        reset = 1'b1;
        wr_en = 1'b0;
        addr  = 32'd0;
        wdata = 32'd0;
        key   = 4'hF;
        sw    = 10'h000;

        // Step 1: reset state, during and after reset
        #12;
        check_display("reset");
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("banner", {22'd0, hex5, hex4, hex3, hex2, hex1, hex0},
              {22'd0, 7'h0E, 7'h06, 7'h21, 7'h06, 7'h08, 7'h21});
        check_display("post_reset");

        // Step 2: HEX store, upper byte ignored
        bus_cycle(1'b1, A_HEX, 32'hAB123456);
        check("hex_store", {22'd0, hex5, hex4, hex3, hex2, hex1, hex0},
              {22'd0, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02});
        check_display("hex_store");

        // Step 3: LEDR store, then alias address must not write
        bus_cycle(1'b1, A_LEDR, 32'hFFFFFFFF);
        check("ledr_all", {54'd0, ledr}, {54'd0, 10'h3FF});
        bus_cycle(1'b1, 32'hFFFFF024, 32'h00000000);
        check("ledr_alias", {54'd0, ledr}, {54'd0, 10'h3FF});
        check_display("alias");

        // Step 4: reads
        key = 4'b1110; addr = A_KEY; #1;
        check("key_rd", {32'd0, rdata}, {32'd0, 32'h1});
        check("key_hit", {63'd0, io_hit}, {63'd0, 1'b1});
        sw = 10'h2A5; addr = A_SW; #1;
        check("sw_rd", {32'd0, rdata}, {32'd0, 32'h2A5});
        check_read("sw");
        addr = A_HEX; #1;
        check_read("hex_rd");

        // Stores to the read-only addresses change nothing
        bus_cycle(1'b1, A_KEY, 32'h12345678);
        bus_cycle(1'b1, A_SW, 32'h87654321);
        check_display("ro_store");

        // Step 5: wr_en low leaves HEX alone
        bus_cycle(1'b0, A_HEX, 32'h00999999);
        check_display("no_we");

        // Randomized stores and loads
        addr_pool = '{A_HEX, A_LEDR, A_KEY, A_SW, A_HEX + 32'd4, A_LEDR + 32'd4, 32'h0};
        for (int i = 0; i < 60; i++) begin
            logic [31:0] a;
            a = addr_pool[$urandom_range(6)];
            if (a == 32'h0) a = $urandom;
            key = 4'($urandom);
            sw  = 10'($urandom);
            bus_cycle(1'($urandom), a, $urandom);
            check_display($sformatf("rnd%0d", i));
            check_read($sformatf("rnd%0d", i));
        end

        // Step 6: asynchronous reset between edges after writes
        bus_cycle(1'b1, A_HEX, 32'h00012345);
        bus_cycle(1'b1, A_LEDR, 32'h0000015A);
        check_display("pre_async");
        #2;
        reset = 1'b1;
        hex_m  = 24'hFEDEAD;
        ledr_m = 10'h000;
        #1;
        check_display("async_rst");
        @(negedge clk);
        reset = 1'b0;

        // Reset held across an edge overrides a simultaneous write
        bus_cycle(1'b1, A_LEDR, 32'h000003C3);
        wr_en = 1'b1; addr = A_HEX; wdata = 32'h00777777;
        #1;
        reset = 1'b1;
        hex_m  = 24'hFEDEAD;
        ledr_m = 10'h000;
        @(posedge clk);
        #1;
        check_display("rst_vs_write");
        wr_en = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_display("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
